// File: rtl/score_bcd_converter.sv
// Serial binary-to-BCD converter (shift-add-3) for the score text renderer.
// Saturates the 32-bit score, converts over BIN_W cycles, and holds five registered digits.
module score_bcd_converter #(
    parameter int BIN_W     = 17,
    parameter int MAX_SCORE = 99999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] score,
    output logic        busy,
    output logic        done,
    output logic [3:0]  dig_10000s,
    output logic [3:0]  dig_1000s,
    output logic [3:0]  dig_100s,
    output logic [3:0]  dig_10s,
    output logic [3:0]  dig_1s
);
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0] MAX32 = 32'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nx;
    logic [BIN_W-1:0]   bin_sr, bin_nx;
    logic [19:0]        bcd_sr, bcd_nx, bcd_adj;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [19:0]        dig_q, dig_nx;
    logic               done_nx;
    logic [BIN_W-1:0]   sat;

    // Compare on the full 32 bits so large scores clamp instead of wrapping.
    assign sat = (score > MAX32) ? MAX32[BIN_W-1:0] : score[BIN_W-1:0];

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 5; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            dig_q  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            bin_sr <= bin_nx;
            bcd_sr <= bcd_nx;
            cnt    <= cnt_nx;
            dig_q  <= dig_nx;
            done   <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bin_nx   = bin_sr;
        bcd_nx   = bcd_sr;
        cnt_nx   = cnt;
        dig_nx   = dig_q;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    bin_nx   = sat;
                    bcd_nx   = '0;
                    cnt_nx   = CNT_W'(BIN_W);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nx = {bcd_adj[18:0], bin_sr[BIN_W-1]};
                bin_nx = {bin_sr[BIN_W-2:0], 1'b0};
                cnt_nx = cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    state_nx = DONE;
            end
            DONE: begin
                // Digits only ever move here, so the renderer never sees a partial result.
                dig_nx   = bcd_sr;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign dig_10000s = dig_q[19:16];
    assign dig_1000s  = dig_q[15:12];
    assign dig_100s   = dig_q[11:8];
    assign dig_10s    = dig_q[7:4];
    assign dig_1s     = dig_q[3:0];
endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: scoreboard of expected digits, checked on each done pulse.
module tb_score_bcd_converter;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] score;
    logic        busy, done;
    logic [3:0]  dig_10000s, dig_1000s, dig_100s, dig_10s, dig_1s;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat;
    int          dcyc[3];
    int          nd;
    logic [19:0] last_dig = '0;
    logic [19:0] exp_dig;
    logic [19:0] sb[$];

    score_bcd_converter dut (
        .clk(clk), .reset(reset), .start(start), .score(score),
        .busy(busy), .done(done),
        .dig_10000s(dig_10000s), .dig_1000s(dig_1000s), .dig_100s(dig_100s),
        .dig_10s(dig_10s), .dig_1s(dig_1s)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] model(input logic [31:0] s);
        int unsigned v;
        v = (s > 32'd99999) ? 99999 : s;
        return {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [19:0] cur();
        return {dig_10000s, dig_1000s, dig_100s, dig_10s, dig_1s};
    endfunction

    // One clock; check done against the scoreboard and digit stability otherwise.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            last_dig = cur();
        end else if (done) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_done cycle=%0d got digits %h with empty scoreboard", cyc, cur());
            end
            if (sb.size() > 0) begin
                exp_dig = sb.pop_front();
                n_assert++;
                assert (cur() === exp_dig) else begin
                    n_fail++;
                    $error("FAIL digits cycle=%0d observed=%h expected=%h", cyc, cur(), exp_dig);
                end
            end
            last_dig = cur();
        end else begin
            n_assert++;
            assert (cur() === last_dig) else begin
                n_fail++;
                $error("FAIL stable cycle=%0d observed=%h expected=%h", cyc, cur(), last_dig);
            end
        end
    endtask

    task automatic wait_done(input int already, output int l);
        l = -1;
        for (int k = already + 1; k <= 40; k++) begin
            tick();
            if (k == 17) begin
                n_assert++;
                assert (busy === 1'b1) else begin
                    n_fail++;
                    $error("FAIL busy_mid observed=%b expected=1", busy);
                end
            end
            if (done) begin
                l = k;
                break;
            end
        end
        n_assert++;
        assert (l == 18) else begin
            n_fail++;
            $error("FAIL latency observed=%0d expected=18", l);
        end
    endtask

    task automatic convert(input logic [31:0] s);
        start = 1'b1;
        score = s;
        sb.push_back(model(s));
        tick();
        start = 1'b0;
        score = $urandom;
        wait_done(0, lat);
        tick();
        n_assert++;
        assert (busy === 1'b0 && done === 1'b0) else begin
            n_fail++;
            $error("FAIL post_done busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        score = '0;
        #3;
        n_assert++;
        assert (cur() === 20'h0 && busy === 1'b0 && done === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_state digits=%h busy=%b done=%b expected 0", cur(), busy, done);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1-3: basic conversions and saturation
        convert(32'd0);
        convert(32'd12345);
        repeat (10) tick();
        convert(32'd99999);
        convert(32'd100000);
        convert(32'hFFFF_FFFF);

        // 4: start while busy is ignored
        start = 1'b1;
        score = 32'd42;
        sb.push_back(model(32'd42));
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        score = 32'd777;
        tick();
        start = 1'b0;
        wait_done(5, lat);
        repeat (30) tick();

        // 5: reset mid-conversion aborts without a done pulse
        convert(32'd12345);
        start = 1'b1;
        score = 32'd54321;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #2;
        n_assert++;
        assert (cur() === 20'h0 && busy === 1'b0 && done === 1'b0) else begin
            n_fail++;
            $error("FAIL abort_reset digits=%h busy=%b done=%b expected 0", cur(), busy, done);
        end
        tick();
        reset = 1'b0;
        repeat (30) tick();
        convert(32'd8);

        // 6: start held high restarts every BIN_W+2 cycles
        start = 1'b1;
        score = 32'd65535;
        repeat (3) sb.push_back(model(32'd65535));
        nd = 0;
        for (int k = 0; k < 100 && nd < 3; k++) begin
            tick();
            if (done) begin
                dcyc[nd] = cyc;
                nd++;
            end
        end
        start = 1'b0;
        n_assert++;
        assert (nd == 3 && dcyc[1] - dcyc[0] == 19 && dcyc[2] - dcyc[1] == 19) else begin
            n_fail++;
            $error("FAIL held_start_period dones=%0d gaps=%0d,%0d expected 3 dones gaps 19,19",
                   nd, dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
        end
        repeat (25) tick();

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d entries expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
